// File: rtl/rx_fifo_stage_multi_if.sv
// Handshake bundle for the multi-entry RX FIFO stage.
// Groups the upstream FIFO side and the collector side of the stage.
// The stage itself connects through the master modport; whatever sits
// on the other side (upstream FIFO plus collector) uses the slave modport.
interface rx_fifo_stage_multi_if #(
  parameter int WR_WIDTH = 48
);
  logic                canpop_fifo;
  logic                pop_fifo;
  logic [WR_WIDTH-1:0] data_fifo;
  logic                data_valid_fifo;
  logic                canpop_collector;
  logic                pop_collector;
  logic [WR_WIDTH-2:0] data_collector;
  logic                data_valid_collector;
  logic                issync_collector;

  modport master (
    input  canpop_fifo,
    input  data_fifo,
    input  data_valid_fifo,
    input  pop_collector,
    output pop_fifo,
    output canpop_collector,
    output data_collector,
    output data_valid_collector,
    output issync_collector
  );

  modport slave (
    output canpop_fifo,
    output data_fifo,
    output data_valid_fifo,
    output pop_collector,
    input  pop_fifo,
    input  canpop_collector,
    input  data_collector,
    input  data_valid_collector,
    input  issync_collector
  );
endinterface

// File: rtl/rx_fifo_stage_multi.sv
// Multi-entry elastic RX FIFO stage between the clock-crossing FIFO and
// the collector. Words may be forced in without a request while
// dissynchronised; a forced write into a full buffer drops the oldest
// entry and raises a sticky overflow flag. Sync words consumed by the
// collector feed a consecutive-match filter that yields the remote
// block-lock vector.
module rx_fifo_stage_multi #(
  parameter int WR_WIDTH  = 48,
  parameter int DEPTH     = 4,
  parameter int LANES     = 4,
  parameter int LOCK_FILT = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_enable,
  rx_fifo_stage_multi_if.master    bus,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
  output logic [LANES-1:0]         out_blocklock_remote,
  output logic                     out_blocklock_remote_en
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(LOCK_FILT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [MW-1:0] FILT_CNT = MW'(LOCK_FILT);

  logic [WR_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic [LANES-1:0]    cand;
  logic [MW-1:0]       match_cnt;

  logic [WR_WIDTH-1:0] head;
  logic                not_empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                forced;
  logic                sync_pop;
  logic [LANES-1:0]    head_lanes;
  logic                lane_match;
  logic [MW-1:0]       match_next;

  // Head decode, handshake qualifiers and the lock filter's next match count
  always_comb begin
    head       = mem[rd_ptr];
    not_empty  = (count != '0);
    full       = (count == FULL_CNT);
    push       = in_enable & bus.data_valid_fifo;
    pop        = in_enable & bus.pop_collector & not_empty;
    forced     = push & full & ~pop;
    sync_pop   = pop & head[WR_WIDTH-1];
    head_lanes = head[LANES-1:0];
    lane_match = (head_lanes == cand);
    match_next = MW'(1);
    if (lane_match) begin
      match_next = (match_cnt == FILT_CNT) ? match_cnt : match_cnt + 1'b1;
    end
  end

  // Collector side is driven straight from the head entry; upstream pop is
  // requested whenever a slot is free or one is being freed this cycle
  always_comb begin
    bus.canpop_collector     = not_empty;
    bus.data_collector       = head[WR_WIDTH-2:0];
    bus.issync_collector     = head[WR_WIDTH-1] & not_empty;
    bus.data_valid_collector = pop;
    bus.pop_fifo             = in_enable & bus.canpop_fifo & ((count < FULL_CNT) | pop);
  end

  // Storage array; contents are meaningless until count says otherwise
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= bus.data_fifo;
    end
  end

  // Pointers, occupancy and the sticky overflow flag; a forced write into
  // a full buffer advances the read pointer to discard the oldest word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else if (in_enable) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop || forced) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop && !full) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (forced) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  // Remote lock filter: only a run of LOCK_FILT identical consumed sync
  // words is allowed to change the published lock vector
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cand                 <= '1;
      match_cnt            <= '0;
      out_blocklock_remote <= '1;
    end else if (sync_pop) begin
      cand      <= head_lanes;
      match_cnt <= match_next;
      if (match_next == FILT_CNT) begin
        out_blocklock_remote <= head_lanes;
      end
    end
  end

  // One-cycle strobe following every consumed sync word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_blocklock_remote_en <= 1'b0;
    end else begin
      out_blocklock_remote_en <= sync_pop;
    end
  end

endmodule

// File: tb/tb_rx_fifo_stage_multi.sv
// Testbench for rx_fifo_stage_multi: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_rx_fifo_stage_multi;

  localparam int W  = 48;
  localparam int D  = 4;
  localparam int L  = 4;
  localparam int LF = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_enable;
  logic         ovf_clr;
  logic         ovf_sticky;
  logic [L-1:0] out_blocklock_remote;
  logic         out_blocklock_remote_en;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] q [$];
  logic [L-1:0] hist [$];
  logic         exp_ovf;
  logic [L-1:0] exp_bl;
  logic         exp_en;

  rx_fifo_stage_multi_if #(.WR_WIDTH(W)) bus ();

  rx_fifo_stage_multi #(
    .WR_WIDTH (W),
    .DEPTH    (D),
    .LANES    (L),
    .LOCK_FILT(LF)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .in_enable              (in_enable),
    .bus                    (bus),
    .ovf_clr                (ovf_clr),
    .ovf_sticky             (ovf_sticky),
    .out_blocklock_remote   (out_blocklock_remote),
    .out_blocklock_remote_en(out_blocklock_remote_en)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] sw(input logic [L-1:0] lanes);
    sw = {1'b1, {(W-1-L){1'b0}}, lanes};
  endfunction

  function automatic logic [W-1:0] dw(input logic [31:0] v);
    dw = {1'b0, {(W-33){1'b0}}, v};
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic en, input logic cf, input logic dv,
                               input logic [W-1:0] d, input logic pc, input logic clr);
    reset_n             = rn;
    in_enable           = en;
    bus.canpop_fifo     = cf;
    bus.data_valid_fifo = dv;
    bus.data_fifo       = d;
    bus.pop_collector   = pc;
    ovf_clr             = clr;
  endtask

  task automatic checkOutput();
    logic canpop;
    logic popx;
    logic popf;
    canpop = (q.size() != 0);
    popx   = in_enable & bus.pop_collector & canpop;
    popf   = in_enable & bus.canpop_fifo & ((q.size() < D) | popx);
    checkValue("canpop_collector", bus.canpop_collector, canpop);
    if (canpop) begin
      checkValue("data_collector", bus.data_collector, q[0][W-2:0]);
      checkValue("issync_collector", bus.issync_collector, q[0][W-1]);
    end else begin
      checkValue("issync_empty", bus.issync_collector, 1'b0);
    end
    checkValue("data_valid_collector", bus.data_valid_collector, popx);
    checkValue("pop_fifo", bus.pop_fifo, popf);
    checkValue("ovf_sticky", ovf_sticky, exp_ovf);
    checkValue("blocklock_remote", out_blocklock_remote, exp_bl);
    checkValue("blocklock_remote_en", out_blocklock_remote_en, exp_en);
  endtask

  // Model update at a clock edge: pop first, then a forced discard, then push
  task automatic modelUpdate();
    logic         popx;
    logic         pushx;
    logic         was_full;
    logic         syncp;
    logic [W-1:0] w;
    bit           all_eq;
    if (!reset_n) begin
      q.delete();
      hist.delete();
      exp_ovf = 1'b0;
      exp_bl  = '1;
      exp_en  = 1'b0;
    end else begin
      popx     = in_enable & bus.pop_collector & (q.size() != 0);
      pushx    = in_enable & bus.data_valid_fifo;
      was_full = (q.size() == D);
      syncp    = 1'b0;
      if (popx) begin
        w = q.pop_front();
        if (w[W-1]) begin
          syncp = 1'b1;
          hist.push_back(w[L-1:0]);
          if (hist.size() > LF) void'(hist.pop_front());
          if (hist.size() == LF) begin
            all_eq = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
            if (all_eq) exp_bl = w[L-1:0];
          end
        end
      end
      if (in_enable) begin
        if (pushx && was_full && !popx) begin
          void'(q.pop_front());
          exp_ovf = 1'b1;
        end else if (ovf_clr) begin
          exp_ovf = 1'b0;
        end
        if (pushx) q.push_back(bus.data_fifo);
      end
      exp_en = syncp;
    end
  endtask

  task automatic step(input logic rn, input logic en, input logic cf, input logic dv,
                      input logic [W-1:0] d, input logic pc, input logic clr);
    applyStimulus(rn, en, cf, dv, d, pc, clr);
    #1;
    checkOutput();
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  task automatic go(input logic en, input logic dv, input logic [W-1:0] d,
                    input logic pc, input logic clr);
    step(1'b1, en, 1'b1, dv, d, pc, clr);
  endtask

  initial begin
    logic [W-1:0] rw;
    logic [L-1:0] lanes;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    modelUpdate();
    $display("[TB] reset state");
    go(1, 0, '0, 0, 0);

    $display("[TB] fill and drain");
    for (int i = 1; i <= 4; i++) go(1, 1, dw(i), 0, 0);
    go(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) go(1, 0, '0, 1, 0);
    go(1, 0, '0, 0, 0);

    $display("[TB] simultaneous push and pop");
    for (int i = 1; i <= 4; i++) go(1, 1, dw(i), 0, 0);
    go(1, 1, dw(5), 1, 0);
    for (int i = 0; i < 4; i++) go(1, 0, '0, 1, 0);
    go(1, 1, dw(6), 1, 0);
    go(1, 0, '0, 1, 0);
    go(1, 0, '0, 0, 0);

    $display("[TB] forced overflow");
    for (int i = 1; i <= 4; i++) go(1, 1, dw(i), 0, 0);
    go(1, 1, dw(32'hA), 0, 0);
    for (int i = 0; i < 4; i++) go(1, 0, '0, 1, 0);
    go(1, 0, '0, 0, 1);
    for (int i = 1; i <= 4; i++) go(1, 1, dw(i), 0, 0);
    go(1, 1, dw(32'hB), 0, 1);
    go(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) go(1, 0, '0, 1, 1);
    go(1, 0, '0, 0, 0);

    $display("[TB] lock filter");
    go(1, 1, sw(4'h5), 0, 0);
    go(1, 1, sw(4'h5), 0, 0);
    go(1, 1, sw(4'h3), 0, 0);
    go(1, 1, dw(32'h7), 0, 0);
    go(1, 0, '0, 1, 0);
    go(1, 1, sw(4'h5), 1, 0);
    for (int i = 0; i < 4; i++) go(1, 0, '0, 1, 0);
    go(1, 0, '0, 0, 0);
    go(1, 0, '0, 0, 0);

    $display("[TB] in_enable low");
    go(1, 1, dw(32'h21), 0, 0);
    go(1, 1, sw(4'h9), 0, 0);
    for (int i = 0; i < 10; i++) go(0, 1, dw($urandom), 1, 1);
    go(1, 0, '0, 0, 0);

    $display("[TB] reset mid-stream");
    go(1, 0, '0, 1, 0);
    go(1, 0, '0, 1, 0);
    go(1, 1, dw(32'h31), 0, 0);
    go(1, 1, dw(32'h32), 0, 0);
    go(1, 1, dw(32'h33), 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, dw(32'h34), 1'b1, 1'b0);
    go(1, 1, dw(32'h77), 0, 0);
    go(1, 0, '0, 1, 0);
    go(1, 0, '0, 0, 0);

    $display("[TB] randomized run");
    for (int n = 0; n < 600; n++) begin
      rw = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: lanes = 4'h5;
          1: lanes = 4'h3;
          2: lanes = 4'hF;
          default: lanes = L'($urandom);
        endcase
        rw = sw(lanes);
        rw[W-2:L] = W-1-L'({$urandom, $urandom});
      end else begin
        rw[W-1] = 1'b0;
      end
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, rw, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
